// File: rtl/mandel_line_scheduler_pkg.sv
// Shared types, default sizes and the round-robin pick function for the
// Mandelbrot line scheduler.
package mandel_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } sched_state_t;

   localparam int X_SIZE_DEF  = 640;
   localparam int Y_SIZE_DEF  = 480;
   localparam int DEPTH_W_DEF = 10;
   localparam int MAX_ENGINES = 8;

   // One-hot grant to the first set request at or above ptr, wrapping at n.
   function automatic logic [MAX_ENGINES-1:0] rr_pick(
      input logic [MAX_ENGINES-1:0] req,
      input logic [2:0]             ptr,
      input int                     n
   );
      logic [MAX_ENGINES-1:0] grant;
      logic [2:0]             idx;
      logic                   found;
      grant = '0;
      found = 1'b0;
      for (int k = 0; k < MAX_ENGINES; k++) begin
         if (k < n && !found) begin
            idx = 3'((int'(ptr) + k) % n);
            if (req[idx]) begin
               grant[idx] = 1'b1;
               found      = 1'b1;
            end
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/mandel_line_scheduler_rr_arbiter.sv
// N-wide round-robin arbiter: combinational one-hot grant, pointer moves
// just past the granted requester whenever the grant is accepted.
module rr_arbiter
   import mandel_sched_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         enable,
   input  logic [N-1:0] req,
   input  logic         accept,
   output logic [N-1:0] grant
);

   logic [2:0]             ptr_reg;
   logic [2:0]             ptr_next;
   logic [MAX_ENGINES-1:0] pick;
   logic                   unused_pick;

   always_comb begin
      pick  = rr_pick(MAX_ENGINES'(req), ptr_reg, N);
      grant = enable ? pick[N-1:0] : '0;
   end

   assign unused_pick = ^pick;

   // With a single requester the pointer wraps straight back to 0.
   always_comb begin
      ptr_next = ptr_reg;
      if (accept) begin
         for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
               ptr_next = (i == N - 1) ? 3'd0 : 3'(i + 1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg <= '0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end

endmodule

// File: rtl/mandel_line_scheduler.sv
// Dispatches one scan line of pixels across NUM_ENGINES engines and writes
// their depth results back. Define SCHED_PERF_EN to add the line_cycles counter.
module mandel_line_scheduler
   import mandel_sched_pkg::*;
#(
   parameter int NUM_ENGINES = 4,
   parameter int X_SIZE      = X_SIZE_DEF,
   parameter int Y_SIZE      = Y_SIZE_DEF,
   parameter int DEPTH_W     = DEPTH_W_DEF,
   parameter int XW          = $clog2(X_SIZE)
) (
   input  logic                           out_stream_aclk,
   input  logic                           periph_resetn,
   input  logic                           line_start,
   input  logic [8:0]                     line_y,
   output logic [8:0]                     cur_y,
   output logic                           busy,
   output logic                           line_done,
   output logic [NUM_ENGINES-1:0]         req_valid,
   input  logic [NUM_ENGINES-1:0]         req_ready,
   output logic [XW-1:0]                  req_x,
   input  logic [NUM_ENGINES-1:0]         res_valid,
   output logic [NUM_ENGINES-1:0]         res_ready,
   input  logic [NUM_ENGINES*XW-1:0]      res_x,
   input  logic [NUM_ENGINES*DEPTH_W-1:0] res_depth,
   output logic                           we_out,
   output logic [XW-1:0]                  addr_out,
   output logic [DEPTH_W-1:0]             depth_out
`ifdef SCHED_PERF_EN
   ,
   output logic [31:0]                    line_cycles
`endif
);

   // Counters must reach X_SIZE itself, so they carry one extra state.
   localparam int            CW    = $clog2(X_SIZE + 1);
   localparam logic [CW-1:0] X_END = CW'(X_SIZE);

   sched_state_t state_reg, state_next;

   logic [8:0]             cur_y_reg;
   logic [CW-1:0]          next_x_reg;
   logic [CW-1:0]          wr_cnt_reg;
   logic                   we_reg;
   logic [XW-1:0]          addr_reg;
   logic [DEPTH_W-1:0]     depth_reg;

   logic                   start_accept;
   logic                   disp_en;
   logic                   col_en;
   logic                   disp_fire;
   logic                   col_fire;
   logic [NUM_ENGINES-1:0] disp_grant;
   logic [NUM_ENGINES-1:0] col_grant;
   logic [XW-1:0]          sel_x;
   logic [DEPTH_W-1:0]     sel_depth;

   always_comb begin
      state_next   = state_reg;
      start_accept = 1'b0;
      disp_en      = 1'b0;
      col_en       = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (line_start) begin
               start_accept = 1'b1;
               state_next   = S_RUN;
            end
         end
         S_RUN: begin
            disp_en = (next_x_reg != X_END);
            col_en  = 1'b1;
            if (next_x_reg == X_END) state_next = S_DRAIN;
         end
         S_DRAIN: begin
            col_en = 1'b1;
            if (wr_cnt_reg == X_END) state_next = S_DONE;
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   rr_arbiter #(.N(NUM_ENGINES)) u_disp_arb (
      .clk    (out_stream_aclk),
      .rst_n  (periph_resetn),
      .enable (disp_en),
      .req    (req_ready),
      .accept (disp_fire),
      .grant  (disp_grant)
   );

   rr_arbiter #(.N(NUM_ENGINES)) u_col_arb (
      .clk    (out_stream_aclk),
      .rst_n  (periph_resetn),
      .enable (col_en),
      .req    (res_valid),
      .accept (col_fire),
      .grant  (col_grant)
   );

   assign disp_fire = |(disp_grant & req_ready);
   assign col_fire  = |(col_grant & res_valid);

   always_comb begin
      sel_x     = '0;
      sel_depth = '0;
      for (int i = 0; i < NUM_ENGINES; i++) begin
         if (col_grant[i]) begin
            sel_x     = res_x[i*XW +: XW];
            sel_depth = res_depth[i*DEPTH_W +: DEPTH_W];
         end
      end
   end

   always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
      if (!periph_resetn) begin
         state_reg  <= S_IDLE;
         cur_y_reg  <= '0;
         next_x_reg <= '0;
         wr_cnt_reg <= '0;
         we_reg     <= 1'b0;
         addr_reg   <= '0;
         depth_reg  <= '0;
      end else begin
         state_reg <= state_next;
         we_reg    <= col_fire;
         if (col_fire) begin
            addr_reg  <= sel_x;
            depth_reg <= sel_depth;
         end
         if (start_accept) begin
            // Out-of-range line numbers are clamped to the last frame line.
            cur_y_reg  <= (32'(line_y) < Y_SIZE) ? line_y : 9'(Y_SIZE - 1);
            next_x_reg <= '0;
            wr_cnt_reg <= '0;
         end else begin
            if (disp_fire) next_x_reg <= next_x_reg + 1'b1;
            if (col_fire)  wr_cnt_reg <= wr_cnt_reg + 1'b1;
         end
      end
   end

   assign cur_y     = cur_y_reg;
   assign busy      = (state_reg != S_IDLE);
   assign line_done = (state_reg == S_DONE);
   assign req_valid = disp_grant;
   assign req_x     = next_x_reg[XW-1:0];
   assign res_ready = col_grant;
   assign we_out    = we_reg;
   assign addr_out  = addr_reg;
   assign depth_out = depth_reg;

`ifdef SCHED_PERF_EN
   logic [31:0] cyc_cnt_reg;
   logic [31:0] line_cycles_reg;

   always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
      if (!periph_resetn) begin
         cyc_cnt_reg     <= '0;
         line_cycles_reg <= '0;
      end else begin
         if (start_accept) begin
            cyc_cnt_reg <= '0;
         end else if (state_reg != S_IDLE) begin
            cyc_cnt_reg <= cyc_cnt_reg + 32'd1;
         end
         if (state_reg == S_DONE) line_cycles_reg <= cyc_cnt_reg;
      end
   end

   assign line_cycles = line_cycles_reg;
`endif

endmodule

// File: tb/tb_mandel_line_scheduler.sv
// Scoreboard bench for mandel_line_scheduler: pipelined engine models feed
// results, expected writes are queued on accept and checked against we_out.
module tb_mandel_line_scheduler;

   localparam int NE = 4;
   localparam int XS = 16;
   localparam int DW = 10;
   localparam int XW = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             line_start = 1'b0;
   logic [8:0]       line_y = '0;
   logic [8:0]       cur_y;
   logic             busy;
   logic             line_done;
   logic [NE-1:0]    req_valid;
   logic [NE-1:0]    req_ready;
   logic [XW-1:0]    req_x;
   logic [NE-1:0]    res_valid;
   logic [NE-1:0]    res_ready;
   logic [NE*XW-1:0] res_x;
   logic [NE*DW-1:0] res_depth;
   logic             we_out;
   logic [XW-1:0]    addr_out;
   logic [DW-1:0]    depth_out;

   always #5 clk = ~clk;

   mandel_line_scheduler #(
      .NUM_ENGINES (NE),
      .X_SIZE      (XS),
      .Y_SIZE      (480),
      .DEPTH_W     (DW),
      .XW          (XW)
   ) dut (
      .out_stream_aclk (clk),
      .periph_resetn   (rst_n),
      .line_start      (line_start),
      .line_y          (line_y),
      .cur_y           (cur_y),
      .busy            (busy),
      .line_done       (line_done),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_x           (req_x),
      .res_valid       (res_valid),
      .res_ready       (res_ready),
      .res_x           (res_x),
      .res_depth       (res_depth),
      .we_out          (we_out),
      .addr_out        (addr_out),
      .depth_out       (depth_out)
   );

   int n_checks = 0;
   int n_pass   = 0;

   int cyc = 0;
   int lat[NE];
   bit hold_res = 1'b0;
   bit fair_chk = 1'b1;
   bit con_chk  = 1'b0;
   int y_model  = 0;

   int jx[NE][$];
   int jt[NE][$];
   int sb_x[$];
   int sb_d[$];

   int disp_cnt, acc_cnt, last_acc_cyc, writes_cnt, done_cnt, done_cyc, writes_at_done;
   logic [XS-1:0] addr_seen;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic int dep(input int x);
      return (x * 37 + y_model * 11 + 1) & 1023;
   endfunction

   // Engine array model plus write monitor.
   initial begin : engine_model
      logic [NE-1:0] tr, acc;
      int sx, scyc, x, ex, ed;
      req_ready = '1;
      res_valid = '0;
      res_x     = '0;
      res_depth = '0;
      forever begin
         @(negedge clk);
         tr   = '0;
         acc  = '0;
         sx   = 0;
         scyc = cyc;
         if (rst_n) begin
            tr  = req_valid & req_ready;
            acc = res_valid & res_ready;
            sx  = int'(req_x);
            if (req_valid != '0) check("req_onehot", $countones(req_valid), 1);
            if (res_ready != '0) begin
               check("res_onehot", $countones(res_ready), 1);
               check("res_ready_valid", res_ready & ~res_valid, 0);
            end
         end
         @(posedge clk);
         #1;
         cyc++;
         if (!rst_n) begin
            for (int e = 0; e < NE; e++) begin
               jx[e].delete();
               jt[e].delete();
            end
            sb_x.delete();
            sb_d.delete();
         end else begin
            for (int e = 0; e < NE; e++) begin
               if (tr[e]) begin
                  check("req_x", sx, disp_cnt);
                  if (fair_chk) check("disp_eng", e, disp_cnt % NE);
                  jx[e].push_back(sx);
                  jt[e].push_back(cyc + lat[e]);
                  disp_cnt++;
               end
            end
            for (int e = 0; e < NE; e++) begin
               if (acc[e]) begin
                  if (jx[e].size() == 0) begin
                     check("acc_no_job", 1, 0);
                  end else begin
                     x = jx[e].pop_front();
                     void'(jt[e].pop_front());
                     sb_x.push_back(x);
                     sb_d.push_back(dep(x));
                     if (con_chk) begin
                        check("col_eng", e, acc_cnt % NE);
                        if (acc_cnt > 0) check("col_gap", scyc - last_acc_cyc, 1);
                     end
                     last_acc_cyc = scyc;
                     acc_cnt++;
                  end
               end
            end
            if (we_out) begin
               if (sb_x.size() == 0) begin
                  check("we_unexpected", 1, 0);
               end else begin
                  ex = sb_x.pop_front();
                  ed = sb_d.pop_front();
                  check("addr_out", addr_out, ex);
                  check("depth_out", depth_out, ed);
                  addr_seen[addr_out] = 1'b1;
                  writes_cnt++;
               end
            end
            if (line_done) begin
               done_cnt++;
               done_cyc       = cyc;
               writes_at_done = writes_cnt;
            end
         end
         for (int e = 0; e < NE; e++) begin
            if (rst_n && !hold_res && jx[e].size() > 0 && jt[e][0] <= cyc) begin
               res_valid[e]             = 1'b1;
               res_x[e*XW +: XW]        = XW'(jx[e][0]);
               res_depth[e*DW +: DW]    = DW'(dep(jx[e][0]));
            end else begin
               res_valid[e] = 1'b0;
            end
         end
      end
   end

   task automatic check_zero(input string pfx);
      check({pfx, "_busy"}, busy, 0);
      check({pfx, "_line_done"}, line_done, 0);
      check({pfx, "_req_valid"}, req_valid, 0);
      check({pfx, "_res_ready"}, res_ready, 0);
      check({pfx, "_we_out"}, we_out, 0);
      check({pfx, "_addr_out"}, addr_out, 0);
      check({pfx, "_depth_out"}, depth_out, 0);
      check({pfx, "_cur_y"}, cur_y, 0);
   endtask

   task automatic start_line(input int y);
      disp_cnt       = 0;
      acc_cnt        = 0;
      writes_cnt     = 0;
      done_cnt       = 0;
      done_cyc       = 0;
      writes_at_done = 0;
      last_acc_cyc   = 0;
      addr_seen      = '0;
      y_model        = y;
      line_y         = 9'(y);
      line_start     = 1'b1;
      @(negedge clk);
      line_start = 1'b0;
      check("start_busy", busy, 1);
      check("start_cur_y", cur_y, y);
   endtask

   task automatic finish_line(input int y);
      int n;
      n = 0;
      while (done_cnt == 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("line_done_seen", done_cnt, 1);
      check("writes_at_done", writes_at_done, XS);
      check("addr_cover", addr_seen, {XS{1'b1}});
      check("done_after_accept", done_cyc - last_acc_cyc, 2);
      check("line_cur_y", cur_y, y);
      repeat (3) @(negedge clk);
      check("single_done", done_cnt, 1);
      check("busy_idle", busy, 0);
      check("sb_empty", sb_x.size(), 0);
   endtask

   initial begin : main
      int n;
      for (int e = 0; e < NE; e++) lat[e] = 1;
      #3;
      check_zero("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Line A: results held until all pixels dispatched, then released together.
      hold_res = 1'b1;
      con_chk  = 1'b1;
      start_line(1);
      n = 0;
      while (disp_cnt < XS && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("dispatch_all", disp_cnt, XS);
      check("hold_no_write", writes_cnt, 0);
      hold_res = 1'b0;
      finish_line(1);
      con_chk = 1'b0;

      // Line B: fixed latency 3, a second line_start mid-line is ignored.
      for (int e = 0; e < NE; e++) lat[e] = 3;
      start_line(3);
      n = 0;
      while (disp_cnt < 5 && n < 100) begin
         @(negedge clk);
         n++;
      end
      line_y     = 9'd7;
      line_start = 1'b1;
      @(negedge clk);
      line_start = 1'b0;
      check("ignored_start_cur_y", cur_y, 3);
      finish_line(3);

      // Line C: unequal engine latencies give out-of-order returns.
      lat[0] = 9;
      lat[1] = 2;
      lat[2] = 5;
      lat[3] = 1;
      start_line(9);
      finish_line(9);

      // Line D: asynchronous reset part way through the line.
      for (int e = 0; e < NE; e++) lat[e] = 2;
      start_line(12);
      n = 0;
      while (disp_cnt < 9 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("reached_x9", disp_cnt, 9);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("midreset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Line E: clean line after reset.
      start_line(20);
      finish_line(20);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mandel_line_scheduler.md
Name: mandel_line_scheduler

Overview:
- Sequences one scan line of Mandelbrot work across NUM_ENGINES parallel iteration engines.
- Hands pixel x indices to idle engines in round-robin order and collects their per-pixel depth results through a round-robin arbiter.
- Writes the results to the line results buffer through a single write port, then pulses line_done.
- Sits between the pixel generator's engine start/done logic and the engine array, replacing a single engine.

Parameters:
- NUM_ENGINES, 4, number of iteration engines (1..8).
- X_SIZE, 640, pixels per line.
- Y_SIZE, 480, lines per frame; bounds line_y.
- DEPTH_W, 10, depth result width.
- XW, $clog2(X_SIZE), x index width.

Ports:
- out_stream_aclk  in  1  clock.
- periph_resetn  in  1  asynchronous active-low reset.
- line_start  in  1  pulse; begin a line.
- line_y  in  9  line number; latched on an accepted line_start.
- cur_y  out  9  latched line number, broadcast to the engines.
- busy  out  1  high from an accepted line_start until line_done.
- line_done  out  1  one-cycle pulse when all X_SIZE results are written.
- req_valid  out  NUM_ENGINES  one-hot dispatch to an engine.
- req_ready  in  NUM_ENGINES  engine idle and can accept a pixel.
- req_x  out  XW  x index for the granted engine.
- res_valid  in  NUM_ENGINES  engine holds a result.
- res_ready  out  NUM_ENGINES  one-hot result accept.
- res_x  in  NUM_ENGINES*XW  packed result x, engine i at [i*XW +: XW].
- res_depth  in  NUM_ENGINES*DEPTH_W  packed result depth.
- we_out  out  1  results buffer write enable.
- addr_out  out  XW  results buffer address.
- depth_out  out  DEPTH_W  results buffer data.

Behaviour:
- Reset value of every output is 0. The asynchronous reset clears the FSM, all counters and both round-robin pointers, abandons any line in progress, and drops all valids and readies.
- FSM states:
  - IDLE: on line_start, latch line_y into cur_y, clear next_x and wr_cnt, set busy, go to RUN.
  - RUN: dispatch and collect every cycle. When next_x == X_SIZE, go to DRAIN.
  - DRAIN: collect only. When wr_cnt == X_SIZE, go to DONE.
  - DONE: pulse line_done for one cycle, clear busy, go to IDLE.
- line_start is ignored in every state other than IDLE. It is not queued.
- Dispatch (RUN only):
  - Grant goes to the first engine with req_ready=1, searching from disp_ptr upward with wrap-around.
  - req_valid is combinational from that grant: at most one bit set, and 0 if next_x == X_SIZE.
  - req_x = next_x.
  - A transfer occurs when req_valid[i] & req_ready[i]. On a transfer, next_x increments and disp_ptr moves to i+1 mod NUM_ENGINES.
  - next_x never exceeds X_SIZE.
- Collect (RUN and DRAIN):
  - Grant goes to the first engine with res_valid=1, searching from col_ptr upward with wrap-around; res_ready is set one-hot for that engine.
  - On an accept, register we_out=1, addr_out=res_x slice and depth_out=res_depth slice (latency 1 cycle), increment wr_cnt, and move col_ptr past the granted engine.
  - Otherwise we_out=0; addr_out and depth_out hold their last values.
- Dispatch and collect are independent and may both fire in the same cycle.
- Throughput: at most 1 dispatch and 1 write per cycle.
- Results may return out of order; writes go to res_x, so buffer order is irrelevant.
- wr_cnt counts to X_SIZE inclusive. The last write and line_done are 2 cycles apart: write, DRAIN→DONE, then pulse.
- NUM_ENGINES=1: both pointers are constant 0.

Optional Feature:
- Macro: SCHED_PERF_EN.
- Defined: adds output line_cycles (32 bits). A counter is cleared on an accepted line_start, increments every cycle while busy, and is copied to line_cycles in the DONE cycle. It holds until the next DONE and resets to 0.
- Not defined: the port, the counter and all related logic are absent.

Decomposition:
- Package mandel_sched_pkg holds:
  - the state enum (S_IDLE, S_RUN, S_DRAIN, S_DONE);
  - defaults X_SIZE_DEF=640, Y_SIZE_DEF=480, DEPTH_W_DEF=10;
  - function rr_pick(req, ptr), returning a one-hot grant.
- Sub-module rr_arbiter: NUM_ENGINES-wide round-robin pick with a pointer update on accept. It is instantiated twice, once for dispatch and once for collect.

Test Plan:
- Basic line: NUM_ENGINES=4, X_SIZE=16, engines always ready and returning results after a fixed 3 cycles → 16 writes with addr_out covering 0..15 exactly once, then a single line_done pulse; busy returns to 0.
- Fairness: all req_ready held at 1 → dispatch grants cycle 0,1,2,3,0,…; req_x to engine 2 is 2, 6, 10, 14.
- Out-of-order return: engines have latencies 9, 2, 5, 1 cycles → every depth_out lands at its own addr_out, and line_done occurs only after wr_cnt=16.
- Result contention: all four res_valid asserted in the same cycle → 4 writes on 4 consecutive cycles, order 0,1,2,3, each res_ready pulse exactly one cycle.
- Ignored start: line_start pulsed mid-line with line_y=7 while cur_y=3 → cur_y stays 3, line count unaffected; the next line_start after DONE latches its own line_y.
- Reset mid-line: periph_resetn=0 at x=9 → all outputs 0 immediately (asynchronous); after release, line_start runs a full clean line of 16 writes. With SCHED_PERF_EN defined and 4 one-cycle engines, line_cycles is nonzero and ≥ 16 + 3.
